uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_sched_if.sv | 31 +++
 rtl/uart_tx_sched_rr_arbiter.sv | 22 ++
 rtl/uart_tx_sched.sv | 125 ++++++++++++
 tb/tb_uart_tx_sched.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;
  localparam int NREQ_DEF         = 4;
  localparam int BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    ACK
  } state_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side and transmitter-side signals of the scheduler, bundled.
interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][7:0]  req_data;
  logic [NREQ-1:0]       req_par_en;
  logic [NREQ-1:0]       req_par_typ;
  logic [NREQ-1:0]       ack;
  logic [IDX_W-1:0]      gnt_id;
  logic                  timeout_err;
  logic                  DATA_VALID;
  logic [7:0]            P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Busy;

  modport slave (
    input  req, req_data, req_par_en, req_par_typ, Busy,
    output ack, gnt_id, timeout_err, DATA_VALID, P_DATA, PAR_EN, PAR_TYP
  );

  modport master (
    output req, req_data, req_par_en, req_par_typ, Busy,
    input  ack, gnt_id, timeout_err, DATA_VALID, P_DATA, PAR_EN, PAR_TYP
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching ptr, ptr+1, ... mod NREQ.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);
  // Walk from the farthest offset down so the nearest one to ptr wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        valid = 1'b1;
        index = IDX_W'((int'(ptr) + i) % NREQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ requesters with round-robin grant,
// launch strobe, Busy-rise timeout and per-requester ack. All outputs registered.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_sched_if.slave  bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  gnt, gnt_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NREQ-1:0]   ack, ack_nxt;
  logic              tmo, tmo_nxt;
  logic              dv, dv_nxt;
  logic [7:0]        pdata, pdata_nxt;
  logic              pen, pen_nxt;
  logic              ptyp, ptyp_nxt;

  logic              arb_valid;
  logic [IDX_W-1:0]  arb_idx;
  logic [IDX_W-1:0]  gnt_inc;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (arb_valid),
    .index (arb_idx)
  );

  assign gnt_inc = IDX_W'(wrap_inc(int'(gnt), NREQ));

  // Outputs are computed on the transition into a state so they are
  // visible, registered, during that state (DATA_VALID in LAUNCH, ack in ACK).
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    ack_nxt   = '0;
    tmo_nxt   = 1'b0;
    dv_nxt    = 1'b0;
    pdata_nxt = pdata;
    pen_nxt   = pen;
    ptyp_nxt  = ptyp;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          gnt_nxt   = arb_idx;
          pdata_nxt = bus.req_data[arb_idx];
          pen_nxt   = bus.req_par_en[arb_idx];
          ptyp_nxt  = bus.req_par_typ[arb_idx];
          dv_nxt    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.Busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (int'(cnt_nxt) >= BUSY_TIMEOUT - 1) begin
            tmo_nxt   = 1'b1;
            ptr_nxt   = gnt_inc;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.Busy) begin
          ack_nxt[gnt] = 1'b1;
          ptr_nxt      = gnt_inc;
          state_nxt    = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
      ack   <= '0;
      tmo   <= 1'b0;
      dv    <= 1'b0;
      pdata <= '0;
      pen   <= 1'b0;
      ptyp  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
      tmo   <= tmo_nxt;
      dv    <= dv_nxt;
      pdata <= pdata_nxt;
      pen   <= pen_nxt;
      ptyp  <= ptyp_nxt;
    end
  end

  assign bus.ack         = ack;
  assign bus.gnt_id      = gnt;
  assign bus.timeout_err = tmo;
  assign bus.DATA_VALID  = dv;
  assign bus.P_DATA      = pdata;
  assign bus.PAR_EN      = pen;
  assign bus.PAR_TYP     = ptyp;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: single transfer, round-robin, timeout, reset abort.
module tb_uart_tx_sched;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NREQ(4)) bus();

  uart_tx_sched #(.NREQ(4), .BUSY_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.req         = '0;
    bus.Busy        = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One round-robin transfer: expect grant id, short Busy frame, ack for id.
  task automatic serve(input int id);
    int n;
    n = 0;
    while (bus.DATA_VALID !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("rr_dv", 32'(bus.DATA_VALID), 1);
    chk("rr_gnt", 32'(bus.gnt_id), id);
    chk("rr_data", 32'(bus.P_DATA), 32'h10 + id);
    tick();
    bus.Busy = 1'b1;
    tick();
    tick();
    bus.Busy = 1'b0;
    n = 0;
    while (bus.ack === 4'b0 && n < 6) begin
      tick();
      n++;
    end
    chk("rr_ack", 32'(bus.ack), 32'(1) << id);
    chk("rr_no_tmo", 32'(bus.timeout_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_data    = '0;
    bus.req_par_en  = '0;
    bus.req_par_typ = '0;
    do_reset();

    chk("rst_dv",    32'(bus.DATA_VALID), 0);
    chk("rst_ack",   32'(bus.ack), 0);
    chk("rst_tmo",   32'(bus.timeout_err), 0);
    chk("rst_pdata", 32'(bus.P_DATA), 0);
    chk("rst_gnt",   32'(bus.gnt_id), 0);
    chk("rst_pen",   32'(bus.PAR_EN), 0);
    chk("rst_ptyp",  32'(bus.PAR_TYP), 0);

    // Single transfer; req dropped after grant, data changed mid-frame.
    bus.req_data[0] = 8'hA5;
    bus.req_par_en  = 4'b0001;
    bus.req_par_typ = 4'b0000;
    bus.req         = 4'b0001;
    tick();
    chk("t1_dv",    32'(bus.DATA_VALID), 1);
    chk("t1_pdata", 32'(bus.P_DATA), 32'hA5);
    chk("t1_pen",   32'(bus.PAR_EN), 1);
    chk("t1_ptyp",  32'(bus.PAR_TYP), 0);
    chk("t1_gnt",   32'(bus.gnt_id), 0);
    bus.req = 4'b0000;
    tick();
    chk("t1_dv_once", 32'(bus.DATA_VALID), 0);
    tick();
    bus.Busy = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 4) bus.req_data[0] = 8'h3C;
      chk("t1_busy_noack", 32'(bus.ack), 0);
    end
    chk("t1_pdata_stable", 32'(bus.P_DATA), 32'hA5);
    bus.Busy = 1'b0;
    tick();
    chk("t1_ack",      32'(bus.ack), 32'b0001);
    chk("t1_ack_data", 32'(bus.P_DATA), 32'hA5);
    chk("t1_ack_tmo",  32'(bus.timeout_err), 0);
    tick();
    chk("t1_ack_pulse", 32'(bus.ack), 0);

    // Timeout: Busy never rises.
    do_reset();
    bus.req_data[2] = 8'h77;
    bus.req         = 4'b0100;
    tick();
    chk("t2_gnt", 32'(bus.gnt_id), 2);
    chk("t2_dv",  32'(bus.DATA_VALID), 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t2_no_tmo_early", 32'(bus.timeout_err), 0);
    end
    tick();
    chk("t2_tmo",    32'(bus.timeout_err), 1);
    chk("t2_no_ack", 32'(bus.ack), 0);
    bus.req = 4'b1111;
    tick();
    chk("t2_next_gnt", 32'(bus.gnt_id), 3);
    chk("t2_next_dv",  32'(bus.DATA_VALID), 1);
    chk("t2_tmo_pulse", 32'(bus.timeout_err), 0);

    // Reset during WAIT_DONE.
    do_reset();
    bus.req_data[1] = 8'h5A;
    bus.req_par_en  = 4'b0010;
    bus.req_par_typ = 4'b0010;
    bus.req         = 4'b0010;
    tick();
    chk("t3_ptyp",  32'(bus.PAR_TYP), 1);
    chk("t3_pdata", 32'(bus.P_DATA), 32'h5A);
    tick();
    bus.Busy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t3_rst_pdata", 32'(bus.P_DATA), 0);
    chk("t3_rst_gnt",   32'(bus.gnt_id), 0);
    chk("t3_rst_pen",   32'(bus.PAR_EN), 0);
    chk("t3_rst_ptyp",  32'(bus.PAR_TYP), 0);
    chk("t3_rst_dv",    32'(bus.DATA_VALID), 0);
    chk("t3_rst_ack",   32'(bus.ack), 0);
    reset    = 1'b0;
    bus.Busy = 1'b0;
    bus.req  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_post_ack", 32'(bus.ack), 0);
      chk("t3_post_tmo", 32'(bus.timeout_err), 0);
    end
    bus.req_data[0] = 8'h11;
    bus.req         = 4'b0001;
    tick();
    chk("t3_idle_dv",  32'(bus.DATA_VALID), 1);
    chk("t3_idle_gnt", 32'(bus.gnt_id), 0);

    // Fairness with all four requesting.
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_data[i] = 8'(8'h10 + i);
    bus.req_par_en  = '0;
    bus.req_par_typ = '0;
    bus.req         = 4'b1111;
    serve(0);
    serve(1);
    serve(2);
    serve(3);
    serve(0);
    bus.req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
